updown_counter_sat: RTL
=======================

# updown_counter_sat

Parametrised multi-channel up/down counter with a runtime-selectable wrap or saturate mode, programmable step and parallel load. Each channel's overflow and underflow events latch into sticky flags that software can clear. It supersedes the single-channel, fixed-step, wrap-only counter in the utils/saturation library. It also serves as the shared occupancy/credit counter for the protocol FIFOs and link-level flow control.

## Interface
- WIDTH, 5: counter width per channel in bits; range 0 .. 2^WIDTH-1.
- CHANNELS, 2: number of independent counter channels.
- STEP_W, 3: width of the step input.

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronised externally.
- sat_mode  in  1  global mode: 0 = wrap (modulo 2^WIDTH), 1 = saturate at 0 / 2^WIDTH-1.
- step  in  STEP_W  unsigned increment/decrement amount, shared by all channels.
- increase  in  CHANNELS  per-channel count-up request.
- decrease  in  CHANNELS  per-channel count-down request.
- load  in  CHANNELS  per-channel parallel load strobe.
- load_value  in  CHANNELS*WIDTH  packed load values; channel i uses bits [i*WIDTH +: WIDTH].
- clear_flags  in  CHANNELS  per-channel sticky-flag clear.
- count  out  CHANNELS*WIDTH  packed registered counter values.
- at_max  out  CHANNELS  count == 2^WIDTH-1.
- at_min  out  CHANNELS  count == 0.
- ovf  out  CHANNELS  sticky: an up-step exceeded 2^WIDTH-1.
- unf  out  CHANNELS  sticky: a down-step went below 0.

## Operation
- Reset (asynchronous, rst_n low):
  - count = 0, ovf = 0, unf = 0.
  - Hence at_min = all 1, at_max = all 0.
- Per-channel priority each cycle:
  1. load
  2. increase XOR decrease
  3. hold
- load: count <= load_value slice. Load never sets ovf/unf.
- Simultaneous increase and decrease with no load: hold. No flag change.
- Arithmetic: computed in WIDTH+1 bits. up_sum = count + step; dn_diff = count - step, with borrow detected.
- Up step, wrap mode: count <= up_sum[WIDTH-1:0]. Set ovf if up_sum[WIDTH] = 1.
- Up step, saturate mode: count <= min(up_sum, 2^WIDTH-1). Set ovf if up_sum > 2^WIDTH-1.
- Down step, wrap mode: count <= dn_diff modulo 2^WIDTH. Set unf on borrow.
- Down step, saturate mode: count <= max(dn_diff, 0). Set unf on borrow.
- step = 0: count unchanged and no flags set, even at the boundaries.
- Saturate mode at the boundary:
  - Increase at count = max: count holds and ovf is set.
  - Decrease at 0: count holds and unf is set.
- clear_flags clears both ovf and unf for that channel. If a new event occurs in the same cycle, set wins and the flag stays 1.
- sat_mode may change at any cycle and takes effect on that edge's computation. sat_mode is not registered.
- Channels are fully independent; there is no cross-channel interaction.

## Timing
- count, ovf and unf are registered. Each updates on the clk edge that samples its request, so it is visible one cycle after the request.
- at_max and at_min are combinational decodes of the registered count, with no extra latency.
- One operation per channel per cycle, so throughput is a full rate of one step per cycle.
- If reset asserts mid-operation, all state returns to reset values immediately, regardless of clk. A request pending in that cycle is lost.
- No combinational path from any input to any output.

## Configuration
- Macro: UPDOWN_COUNTER_THRESHOLD_EN.
- Defined:
  - Adds input thr_value (CHANNELS*WIDTH, packed) and output at_thr (CHANNELS).
  - at_thr[i] is registered and equals 1 when the next count >= thr_value slice. It is therefore valid in the same cycle as count.
  - at_thr resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then channel 0 with step=1, increase for 31 cycles, wrap mode → count0 = 31 and at_max0 = 1. One more increase → count0 = 0, ovf0 = 1, at_min0 = 1.
- Saturate mode: load 29, then increase with step=3 → count = 31 and ovf = 1. Then decrease with step=7 twice → 24 then 17, and unf stays 0.
- Simultaneous events:
  - increase and decrease together → count unchanged.
  - load = 10 with increase in the same cycle → count = 10.
  - clear_flags in the same cycle as a new overflow → ovf stays 1.
- Wrap mode: count = 2, decrease with step=5 → count = 29 and unf = 1. Then clear_flags → unf = 0 next cycle, count = 29.
- Channel independence and reset: channel 1 counts up while channel 0 counts down. Assert rst_n low mid-burst without a clk edge → all counts and flags are 0 immediately.
- With UPDOWN_COUNTER_THRESHOLD_EN defined and thr = 8: step=1 increases from 0 → at_thr rises in the same cycle count reaches 8.

Source files
------------

// File: rtl/updown_counter_sat.sv
// Multi-channel up/down counter with wrap/saturate mode, shared step, parallel load
// and sticky overflow/underflow flags. Optional UPDOWN_COUNTER_THRESHOLD_EN adds at_thr.
module updown_counter_sat #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 2,
  parameter int STEP_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sat_mode,
  input  logic [STEP_W-1:0]           step,
  input  logic [CHANNELS-1:0]         increase,
  input  logic [CHANNELS-1:0]         decrease,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS*WIDTH-1:0]   load_value,
  input  logic [CHANNELS-1:0]         clear_flags,
`ifdef UPDOWN_COUNTER_THRESHOLD_EN
  input  logic [CHANNELS*WIDTH-1:0]   thr_value,
  output logic [CHANNELS-1:0]         at_thr,
`endif
  output logic [CHANNELS*WIDTH-1:0]   count,
  output logic [CHANNELS-1:0]         at_max,
  output logic [CHANNELS-1:0]         at_min,
  output logic [CHANNELS-1:0]         ovf,
  output logic [CHANNELS-1:0]         unf
);

  // Extended width keeps the carry even if step is wider than the counter.
  localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
  localparam logic [EW-1:0] MAX_EXT = {{(EW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] dn_wrap;
    logic [EW-1:0]    cnt_ext;
    logic [EW-1:0]    step_ext;
    logic [EW-1:0]    up_sum;
    logic             up_ovf;
    logic             borrow;
    logic             ovf_set;
    logic             unf_set;
    logic             ovf_q;
    logic             unf_q;

    always_comb begin
      cnt_ext  = EW'(cnt_q);
      step_ext = EW'(step);
      up_sum   = cnt_ext + step_ext;
      dn_wrap  = cnt_q - WIDTH'(step);
      up_ovf   = (up_sum > MAX_EXT);
      borrow   = (step_ext > cnt_ext);
      cnt_d    = cnt_q;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      if (load[i]) begin
        cnt_d = load_value[i*WIDTH +: WIDTH];
      end else if (increase[i] && !decrease[i]) begin
        ovf_set = up_ovf;
        cnt_d   = (sat_mode && up_ovf) ? {WIDTH{1'b1}} : up_sum[WIDTH-1:0];
      end else if (decrease[i] && !increase[i]) begin
        unf_set = borrow;
        cnt_d   = (sat_mode && borrow) ? {WIDTH{1'b0}} : dn_wrap;
      end
    end

    // A new event in the same cycle as clear_flags wins.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_set | (ovf_q & ~clear_flags[i]);
        unf_q <= unf_set | (unf_q & ~clear_flags[i]);
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign at_max[i]               = &cnt_q;
    assign at_min[i]               = ~|cnt_q;
    assign ovf[i]                  = ovf_q;
    assign unf[i]                  = unf_q;

`ifdef UPDOWN_COUNTER_THRESHOLD_EN
    // Registered from the next count so it lines up with count itself.
    logic thr_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) thr_q <= 1'b0;
      else        thr_q <= (cnt_d >= thr_value[i*WIDTH +: WIDTH]);
    end
    assign at_thr[i] = thr_q;
`endif
  end

endmodule
